// File: rtl/pipemem_arbiter.sv
// Shares the single-port pipemem between the pipeline MEM stage and a DMA/debug requester.
// Define PIPEMEM_ARB_STARVE_EN to add the starvation guard that forces one DMA access.
module pipemem_arbiter #(
  parameter int unsigned WAIT_MAX = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  if (WAIT_MAX < 1 || WAIT_MAX > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("pipemem_arbiter: WAIT_MAX out of range for CNT_W");
  end

  logic grant_cpu;
  logic grant_dma;
  logic dma_pending;

  // A request is never served in its own ack cycle.
  assign dma_pending = dma_req & ~dma_ack;

`ifdef PIPEMEM_ARB_STARVE_EN
  typedef enum logic [0:0] {ArbCpu, ArbDmaForce} arb_state_e;

  arb_state_e       state_q;
  logic [CNT_W-1:0] starve_cnt_q;

  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    cpu_stall = 1'b0;
    if (state_q == ArbDmaForce) begin
      grant_dma = 1'b1;
      cpu_stall = cpu_req;
    end else begin
      grant_cpu = cpu_req;
      grant_dma = ~cpu_req & dma_pending;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ArbCpu;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        ArbCpu: begin
          if (grant_dma || !dma_pending) begin
            starve_cnt_q <= '0;
          end else if (cpu_req) begin
            if (starve_cnt_q == CNT_W'(WAIT_MAX - 1)) begin
              state_q      <= ArbDmaForce;
              starve_cnt_q <= '0;
            end else begin
              starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q      <= ArbCpu;
          starve_cnt_q <= '0;
        end
      endcase
    end
  end
`else
  assign grant_cpu = cpu_req;
  assign grant_dma = ~cpu_req & dma_pending;
  assign cpu_stall = 1'b0;
`endif

  always_comb begin
    mem_addr   = cpu_addr;
    mem_datain = cpu_wdata;
    mem_we     = 1'b0;
    if (grant_dma) begin
      mem_addr   = dma_addr;
      mem_datain = dma_wdata;
      mem_we     = dma_we;
    end else if (grant_cpu) begin
      mem_we = cpu_we;
    end
    // No write may leak through while reset is held.
    if (!clrn) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
    end else begin
      dma_ack <= grant_dma;
      if (grant_dma) begin
        dma_rdata <= mem_dataout;
      end
    end
  end

endmodule
